channel_scan_sequencer: RTL and testbench

CHANNEL_SCAN_SEQUENCER -- requirements
Module: channel_scan_sequencer

---
 rtl/channel_scan_sequencer_if.sv | 28 ++
 rtl/channel_scan_sequencer.sv | 112 +++++++++++
 tb/tb_channel_scan_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/channel_scan_sequencer_if.sv
// Request/select/capture bundle between the channel scan sequencer and its
// environment (requesters, external data multiplexer, word consumer).
interface channel_scan_sequencer_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NCH    = 8
);
   localparam int unsigned SEL_W = $clog2(NCH);

   logic [NCH-1:0]    req;
   logic [SEL_W-1:0]  sel;
   logic [DATA_W-1:0] mux_y;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_ch;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   logic [15:0]       xfer_cnt;

   modport master (
      input  req, mux_y, out_ready,
      output sel, out_data, out_ch, out_valid, busy, xfer_cnt
   );

   modport slave (
      output req, mux_y, out_ready,
      input  sel, out_data, out_ch, out_valid, busy, xfer_cnt
   );
endinterface

// File: rtl/channel_scan_sequencer.sv
// Round-robin channel scanner: grants a requesting channel, drives the external
// mux select, waits one settle cycle, captures the word and holds it until accepted.
module channel_scan_sequencer #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NCH    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   channel_scan_sequencer_if.master  bus
);
   localparam int unsigned SEL_W = $clog2(NCH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETTLE  = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   logic [1:0]        state_q,     state_d;
   logic [SEL_W-1:0]  sel_q,       sel_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q,      busy_d;
   logic [15:0]       xfer_cnt_q,  xfer_cnt_d;
   logic [SEL_W-1:0]  last_q,      last_d;

   logic              found;
   logic [SEL_W-1:0]  grant;
   logic [SEL_W-1:0]  cand;

   // First asserted request at or above last+1; SEL_W-bit overflow gives the wrap.
   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cand = last_q + SEL_W'(i + 1);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      xfer_cnt_d  = xfer_cnt_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = grant;
               state_d = SETTLE;
            end
         end
         SETTLE: state_d = CAPTURE;
         CAPTURE: begin
            out_data_d  = bus.mux_y;
            out_ch_d    = sel_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
               last_d      = out_ch_q;
               if (xfer_cnt_q != 16'hFFFF) begin
                  xfer_cnt_d = xfer_cnt_q + 16'd1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         xfer_cnt_q  <= '0;
         last_q      <= SEL_W'(NCH - 1);
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         xfer_cnt_q  <= xfer_cnt_d;
         last_q      <= last_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Directed bench for channel_scan_sequencer: stimulus pushes expected words into
// a queue, a negedge monitor pops and compares on every handshake.
module tb_channel_scan_sequencer;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NCH    = 8;
   localparam int unsigned SEL_W  = 3;

   typedef struct packed {
      logic [SEL_W-1:0]  ch;
      logic [DATA_W-1:0] data;
   } word_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   channel_scan_sequencer_if #(.DATA_W(DATA_W), .NCH(NCH)) bus ();

   channel_scan_sequencer #(.DATA_W(DATA_W), .NCH(NCH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External 8-input mux model: channel k returns 8'hA0 + k.
   assign bus.mux_y = 8'hA0 + DATA_W'(bus.sel);

   word_t exp_q[$];
   word_t mon_e;
   int    acc_cyc[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    n_acc = 0;
   int    cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Handshake monitor: values seen at negedge are those sampled at the next posedge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: got ch %0d data %0h, expected none", bus.out_ch, bus.out_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_out_ch", 32'(bus.out_ch), 32'(mon_e.ch));
            chk("sb_out_data", 32'(bus.out_data), 32'(mon_e.data));
         end
         n_acc++;
         acc_cyc.push_back(cyc);
      end
   end

   task automatic push_word(input int ch);
      word_t w;
      w.ch   = SEL_W'(ch);
      w.data = 8'hA0 + DATA_W'(ch);
      exp_q.push_back(w);
   endtask

   // Returns just after the edge that accepts the n-th further word.
   task automatic wait_acc(input int n, input string name);
      int tgt;
      int b;
      tgt = n_acc + n;
      b   = 0;
      while (n_acc < tgt && b < 40 * n) begin
         @(posedge clk);
         b++;
      end
      if (n_acc < tgt) chk({name, "_timeout"}, 32'(n_acc), 32'(tgt));
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b;
      rst           = 1'b1;
      bus.req       = '0;
      bus.out_ready = 1'b0;
      step(2);

      // Reset state
      chk("rst_sel",       32'(bus.sel),       32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
      rst = 1'b0;

      // Single request on channel 4, latency and capture
      bus.req = 8'h10; bus.out_ready = 1'b1;
      push_word(4);
      step(1);
      bus.req = 8'h00;
      chk("e1_sel",   32'(bus.sel),       32'd4);
      chk("e1_busy",  32'(bus.busy),      32'd1);
      chk("e1_valid", 32'(bus.out_valid), 32'd0);
      step(1);
      chk("e2_valid", 32'(bus.out_valid), 32'd0);
      step(1);
      chk("e3_valid", 32'(bus.out_valid), 32'd1);
      chk("e3_data",  32'(bus.out_data),  32'hA4);
      chk("e3_ch",    32'(bus.out_ch),    32'd4);
      wait_acc(1, "ch4");
      chk("ch4_cnt",   32'(bus.xfer_cnt),  32'd1);
      chk("ch4_valid", 32'(bus.out_valid), 32'd0);
      chk("ch4_busy",  32'(bus.busy),      32'd0);

      // All requests held: round robin 0..7,0 at one word per 4 cycles
      do_reset();
      acc_cyc.delete();
      bus.req = 8'hFF; bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) push_word(i % 8);
      wait_acc(9, "rr");
      bus.req = 8'h00;
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
      chk("rr_cnt", 32'(bus.xfer_cnt), 32'd9);

      // Back-pressure on channel 2 with its request withdrawn after grant
      bus.req = 8'h04; bus.out_ready = 1'b0;
      push_word(2);
      step(1);
      bus.req = 8'h00;
      chk("bp_sel", 32'(bus.sel), 32'd2);
      step(2);
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_data",  32'(bus.out_data),  32'hA2);
         chk("bp_sel_hold", 32'(bus.sel),    32'd2);
         step(1);
      end
      bus.out_ready = 1'b1;
      wait_acc(1, "bp");
      chk("bp_cnt", 32'(bus.xfer_cnt), 32'd10);

      // Wrap: last = 6, req 0x41 -> channel 0
      bus.req = 8'h40;
      push_word(6);
      wait_acc(1, "ch6");
      bus.req = 8'h41;
      push_word(0);
      wait_acc(1, "wrap");
      bus.req = 8'h00;

      // Reset mid-HOLD discards the pending word
      bus.req = 8'h01; bus.out_ready = 1'b0;
      b = 0;
      while (!bus.out_valid && b < 20) begin step(1); b++; end
      bus.req = 8'h00;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_cnt",   32'(bus.xfer_cnt),  32'd0);
      chk("arst_busy",  32'(bus.busy),      32'd0);
      step(1);
      rst = 1'b0;
      bus.req = 8'h01; bus.out_ready = 1'b1;
      push_word(0);
      wait_acc(1, "post_rst");
      bus.req = 8'h00;
      chk("post_rst_cnt", 32'(bus.xfer_cnt), 32'd1);

      // Counter saturation
      force dut.xfer_cnt_q = 16'hFFFE;
      step(1);
      release dut.xfer_cnt_q;
      chk("sat_preload", 32'(bus.xfer_cnt), 32'hFFFE);
      bus.req = 8'hFF;
      push_word(1); push_word(2); push_word(3);
      wait_acc(1, "sat1");
      chk("sat_first", 32'(bus.xfer_cnt), 32'hFFFF);
      wait_acc(2, "sat3");
      bus.req = 8'h00;
      chk("sat_final", 32'(bus.xfer_cnt), 32'hFFFF);

      step(4);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
